// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, writeback, hazard and ID/EX signal bundle around the decode stage.
interface decode_stage_if #(parameter int DATA_WIDTH = 32);
  logic [31:0] instruction_in;
  logic [31:0] next_PC_in;
  logic hit;
  logic flush;
  logic writeback_enable;
  logic [4:0] writeback_register;
  logic [DATA_WIDTH-1:0] writeback_data;
  logic ex_mem_read;
  logic [4:0] ex_rt;
  logic stall;
  logic id_valid;
  logic [31:0] id_next_PC;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic [DATA_WIDTH-1:0] sign_extended_immediate;
  logic [31:0] jump_target;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;
  logic reg_write;
  logic mem_read;
  logic mem_write;
  logic mem_to_reg;
  logic alu_src;
  logic reg_dst;
  logic branch;
  logic jump;
  logic [1:0] alu_op;
  modport master (
    output instruction_in, next_PC_in, hit, flush, writeback_enable, writeback_register,
           writeback_data, ex_mem_read, ex_rt,
    input  stall, id_valid, id_next_PC, read_data_1, read_data_2, sign_extended_immediate,
           jump_target, rs, rt, rd, funct, reg_write, mem_read, mem_write, mem_to_reg,
           alu_src, reg_dst, branch, jump, alu_op
  );
  modport slave (
    input  instruction_in, next_PC_in, hit, flush, writeback_enable, writeback_register,
           writeback_data, ex_mem_read, ex_rt,
    output stall, id_valid, id_next_PC, read_data_1, read_data_2, sign_extended_immediate,
           jump_target, rs, rt, rd, funct, reg_write, mem_read, mem_write, mem_to_reg,
           alu_src, reg_dst, branch, jump, alu_op
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: IF/ID latch, decode, register file, load-use stall and ID/EX bank.
// Define WB_BYPASS_EN to forward same-cycle writeback data into the operand reads.
module decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT = 32
) (
  input logic clock,
  input logic reset,
  decode_stage_if.slave bus
);
  localparam logic [9:0] C_R    = 10'b1000010010;
  localparam logic [9:0] C_LW   = 10'b1101100000;
  localparam logic [9:0] C_SW   = 10'b0010100000;
  localparam logic [9:0] C_BEQ  = 10'b0000001001;
  localparam logic [9:0] C_ADDI = 10'b1000100000;
  localparam logic [9:0] C_J    = 10'b0000000100;
  typedef struct packed {
    logic valid;
    logic [31:0] next_pc;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [31:0] jt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    logic [9:0] ctrl;
  } idex_t;
  logic ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  idex_t idex_q, idex_d;
  logic [5:0] op_f;
  logic [4:0] rs_f, rt_f;
  logic reads_rt, stall_c, load_ifid;
  logic [9:0] ctrl_c;
  logic [DATA_WIDTH-1:0] rd1_c, rd2_c;
  assign op_f = ifid_instr_q[31:26];
  assign rs_f = ifid_instr_q[25:21];
  assign rt_f = ifid_instr_q[20:16];
  assign reads_rt = op_f == 6'h00 || op_f == 6'h04 || op_f == 6'h2B;
  assign stall_c = !bus.flush && ifid_valid_q && bus.ex_mem_read && bus.ex_rt != 5'd0 &&
                   (bus.ex_rt == rs_f || (bus.ex_rt == rt_f && reads_rt));
  assign load_ifid = !bus.flush && !stall_c && bus.hit;
  assign ctrl_c = op_f == 6'h00 ? C_R :
                  op_f == 6'h23 ? C_LW :
                  op_f == 6'h2B ? C_SW :
                  op_f == 6'h04 ? C_BEQ :
                  op_f == 6'h08 ? C_ADDI :
                  op_f == 6'h02 ? C_J : 10'b0;
`ifdef WB_BYPASS_EN
  logic wb_live;
  assign wb_live = bus.writeback_enable && bus.writeback_register != 5'd0;
  assign rd1_c = wb_live && bus.writeback_register == rs_f ? bus.writeback_data : regs_q[rs_f];
  assign rd2_c = wb_live && bus.writeback_register == rt_f ? bus.writeback_data : regs_q[rt_f];
`else
  assign rd1_c = regs_q[rs_f];
  assign rd2_c = regs_q[rt_f];
`endif
  always_comb begin
    ifid_valid_d = bus.flush ? 1'b0 : stall_c ? ifid_valid_q : bus.hit;
    ifid_instr_d = load_ifid ? bus.instruction_in : ifid_instr_q;
    ifid_pc_d = load_ifid ? bus.next_PC_in : ifid_pc_q;
    regs_d = regs_q;
    if (bus.writeback_enable && bus.writeback_register != 5'd0)
      regs_d[bus.writeback_register] = bus.writeback_data;
  end
  // Flush and stall both squash the slot; stall keeps IF/ID so the instruction retries.
  always_comb begin
    idex_d = '0;
    if (!bus.flush && !stall_c && ifid_valid_q) begin
      idex_d.valid = 1'b1;
      idex_d.next_pc = ifid_pc_q;
      idex_d.rd1 = rd1_c;
      idex_d.rd2 = rd2_c;
      idex_d.imm = {{(DATA_WIDTH-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};
      idex_d.jt = {ifid_pc_q[31:28], ifid_instr_q[25:0], 2'b00};
      idex_d.rs = rs_f;
      idex_d.rt = rt_f;
      idex_d.rd = ifid_instr_q[15:11];
      idex_d.funct = ifid_instr_q[5:0];
      idex_d.ctrl = ctrl_c;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q <= '0;
      regs_q <= '{default: '0};
      idex_q <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q <= ifid_pc_d;
      regs_q <= regs_d;
      idex_q <= idex_d;
    end
  end
  assign bus.stall = stall_c;
  assign bus.id_valid = idex_q.valid;
  assign bus.id_next_PC = idex_q.next_pc;
  assign bus.read_data_1 = idex_q.rd1;
  assign bus.read_data_2 = idex_q.rd2;
  assign bus.sign_extended_immediate = idex_q.imm;
  assign bus.jump_target = idex_q.jt;
  assign bus.rs = idex_q.rs;
  assign bus.rt = idex_q.rt;
  assign bus.rd = idex_q.rd;
  assign bus.funct = idex_q.funct;
  assign {bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.alu_src,
          bus.reg_dst, bus.branch, bus.jump, bus.alu_op} = idex_q.ctrl;
endmodule
